sorter_stepper_ctrl: RTL and testbench

Parametrised successor to the single-diverter stepper controller for the waste-sorting line. It samples the capacitive, inductive and photo sensors over a settle window and classifies the object as metal, plastic or glass. It then drives the unipolar stepper diverter out by a per-class step count in a per-class direction, dwells, and returns home. Adds half-step mode, an explicit FSM with reject and handshake outputs, sensor synchronisation and object-clear re-arm.

---
 rtl/sorter_stepper_ctrl_pkg.sv | 51 +++++
 rtl/sorter_stepper_ctrl_phase_gen.sv | 53 +++++
 rtl/sorter_stepper_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_sorter_stepper_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sorter_stepper_ctrl_pkg.sv
// Shared types and constants for the waste-sorter diverter controller:
// FSM states, material class codes, stepper phase tables and the sensor
// pattern decoder.
package sorter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    CLASSIFY,
    MOVE_OUT,
    DWELL,
    MOVE_BACK,
    DONE,
    WAIT_CLEAR
  } state_t;

  localparam logic [1:0] CLS_METAL   = 2'd0;
  localparam logic [1:0] CLS_PLASTIC = 2'd1;
  localparam logic [1:0] CLS_GLASS   = 2'd2;

  // Element 0 is the rightmost entry; index 0 is the first phase driven.
  localparam logic [3:0][3:0] FULL_STEP_TABLE = {
    4'b1001, 4'b0011, 4'b0110, 4'b1100
  };

  localparam logic [7:0][3:0] HALF_STEP_TABLE = {
    4'b1001, 4'b0001, 4'b0011, 4'b0010,
    4'b0110, 4'b0100, 4'b1100, 4'b1000
  };

  typedef struct packed {
    logic       valid;
    logic [1:0] cls;
  } class_dec_t;

  // Inductive+photo -> metal, photo only -> plastic, neither -> glass.
  // Inductive without photo is not a known material.
  function automatic class_dec_t decode_class(input logic ind, input logic pho);
    class_dec_t dec;
    dec.valid = 1'b1;
    dec.cls   = CLS_GLASS;
    case ({ind, pho})
      2'b11:   dec.cls = CLS_METAL;
      2'b01:   dec.cls = CLS_PLASTIC;
      2'b00:   dec.cls = CLS_GLASS;
      default: dec.valid = 1'b0;
    endcase
    return dec;
  endfunction

endpackage

// File: rtl/sorter_stepper_ctrl_phase_gen.sv
// Stepper phase generator: keeps the phase index, advances it one position
// per tick in the requested direction and registers the matching coil word.
module stepper_phase_gen
  import sorter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_tick,
  input  logic       i_dir,
  input  logic       i_half_step,
  input  logic       i_clear_out,
  output logic [3:0] o_coil
);

  logic [2:0] r_idx;
  logic [3:0] r_coil;
  logic [2:0] w_idx_step;
  logic [2:0] w_idx_next;
  logic [3:0] w_coil_lookup;

  // Next phase index with wrap, and the coil word for the current index.
  // NOTE: every signal assigned in an always_comb gets a value on every path
  // (here unconditionally); a missed path would infer a latch.
  always_comb begin
    w_idx_step    = i_dir ? (r_idx + 3'd1) : (r_idx - 3'd1);
    w_idx_next    = i_half_step ? w_idx_step : {1'b0, w_idx_step[1:0]};
    w_coil_lookup = i_half_step ? HALF_STEP_TABLE[r_idx]
                                : FULL_STEP_TABLE[r_idx[1:0]];
  end

  // Index and coil registers; the index survives clear so the return move
  // continues from where the outbound move stopped.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx  <= '0;
      r_coil <= '0;
    end else begin
      if (i_tick) begin
        r_idx <= w_idx_next;
      end
      if (i_clear_out) begin
        r_coil <= '0;
      end else if (i_tick) begin
        r_coil <= w_coil_lookup;
      end
    end
  end

  assign o_coil = r_coil;

endmodule

// File: rtl/sorter_stepper_ctrl.sv
// Waste-sorter diverter controller: synchronises the three sensors, samples
// them over a settle window, classifies the object, steps the diverter out
// and back, then waits for the object to leave before re-arming.
module sorter_stepper_ctrl
  import sorter_pkg::*;
#(
  parameter int unsigned STEP_DELAY    = 150000,
  parameter int unsigned DWELL_CYCLES  = 100000000,
  parameter int unsigned SETTLE_CYCLES = 1000,
  parameter logic [15:0] STEPS_METAL   = 16'd300,
  parameter logic [15:0] STEPS_PLASTIC = 16'd300,
  parameter logic [15:0] STEPS_GLASS   = 16'd1000,
  parameter logic [2:0]  DIR_MASK      = 3'b101,
  parameter bit          HALF_STEP     = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       capacitive,
  input  logic       inductive,
  input  logic       photo,
  output logic [3:0] motor_pregrada,
  output logic       busy,
  output logic       class_valid,
  output logic [1:0] class_id,
  output logic       reject,
  output logic       cycle_done
);

  localparam logic [31:0] STEP_LAST   = 32'(STEP_DELAY - 1);
  localparam logic [31:0] DWELL_LAST  = 32'(DWELL_CYCLES - 1);
  localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);

  state_t     r_state;
  state_t     w_state_next;

  logic       r_cap_meta, r_cap_sync;
  logic       r_ind_meta, r_ind_sync;
  logic       r_pho_meta, r_pho_sync;

  logic       r_ind_l, r_pho_l;
  logic [31:0] r_settle_cnt;
  logic [31:0] r_delay_cnt;
  logic [31:0] r_dwell_cnt;
  logic [15:0] r_steps_done;
  logic [15:0] r_target;
  logic       r_dir_out;

  logic       r_class_valid;
  logic [1:0] r_class_id;
  logic       r_reject;
  logic       r_cycle_done;

  class_dec_t w_dec;
  logic       w_tick;
  logic       w_dir;
  logic       w_clear;

  assign w_dec = decode_class(r_ind_l, r_pho_l);

  // Two-flop synchronisers; capacitive idles high (no object) out of reset
  // so the controller cannot arm on the synchroniser's reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cap_meta <= 1'b1;
      r_cap_sync <= 1'b1;
      r_ind_meta <= 1'b0;
      r_ind_sync <= 1'b0;
      r_pho_meta <= 1'b0;
      r_pho_sync <= 1'b0;
    end else begin
      r_cap_meta <= capacitive;
      r_cap_sync <= r_cap_meta;
      r_ind_meta <= inductive;
      r_ind_sync <= r_ind_meta;
      r_pho_meta <= photo;
      r_pho_sync <= r_pho_meta;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode and step tick; a move whose step count is already met
  // leaves before ticking, so a zero target produces no steps.
  always_comb begin
    w_state_next = r_state;
    w_tick       = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable && !r_cap_sync) w_state_next = ARM;
      end
      ARM: begin
        if (r_settle_cnt == SETTLE_LAST) w_state_next = CLASSIFY;
      end
      CLASSIFY: begin
        w_state_next = w_dec.valid ? MOVE_OUT : WAIT_CLEAR;
      end
      MOVE_OUT: begin
        if (r_steps_done == r_target)     w_state_next = DWELL;
        else if (r_delay_cnt == STEP_LAST) w_tick = 1'b1;
      end
      DWELL: begin
        if (r_dwell_cnt == DWELL_LAST) w_state_next = MOVE_BACK;
      end
      MOVE_BACK: begin
        if (r_steps_done == r_target)     w_state_next = DONE;
        else if (r_delay_cnt == STEP_LAST) w_tick = 1'b1;
      end
      DONE: begin
        w_state_next = WAIT_CLEAR;
      end
      WAIT_CLEAR: begin
        if (r_cap_sync) w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Counters, sticky sensor latches and the per-class move setup.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_settle_cnt <= '0;
      r_delay_cnt  <= '0;
      r_dwell_cnt  <= '0;
      r_steps_done <= '0;
      r_target     <= '0;
      r_dir_out    <= 1'b0;
      r_ind_l      <= 1'b0;
      r_pho_l      <= 1'b0;
      r_class_id   <= CLS_METAL;
    end else begin
      if (w_state_next != r_state) begin
        r_settle_cnt <= '0;
        r_delay_cnt  <= '0;
        r_dwell_cnt  <= '0;
        r_steps_done <= '0;
      end else begin
        case (r_state)
          ARM:   r_settle_cnt <= r_settle_cnt + 32'd1;
          DWELL: r_dwell_cnt  <= r_dwell_cnt + 32'd1;
          MOVE_OUT, MOVE_BACK: begin
            if (w_tick) begin
              r_delay_cnt  <= '0;
              r_steps_done <= r_steps_done + 16'd1;
            end else begin
              r_delay_cnt <= r_delay_cnt + 32'd1;
            end
          end
          default: ;
        endcase
      end

      if (r_state == IDLE) begin
        r_ind_l <= r_ind_sync;
        r_pho_l <= r_pho_sync;
      end else if (r_state == ARM) begin
        r_ind_l <= r_ind_l | r_ind_sync;
        r_pho_l <= r_pho_l | r_pho_sync;
      end

      if (r_state == CLASSIFY && w_dec.valid) begin
        r_class_id <= w_dec.cls;
        case (w_dec.cls)
          CLS_METAL: begin
            r_target  <= STEPS_METAL;
            r_dir_out <= DIR_MASK[0];
          end
          CLS_PLASTIC: begin
            r_target  <= STEPS_PLASTIC;
            r_dir_out <= DIR_MASK[1];
          end
          default: begin
            r_target  <= STEPS_GLASS;
            r_dir_out <= DIR_MASK[2];
          end
        endcase
      end
    end
  end

  // Registered one-cycle status pulses so they align with the updated class.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_class_valid <= 1'b0;
      r_reject      <= 1'b0;
      r_cycle_done  <= 1'b0;
    end else begin
      r_class_valid <= (r_state == CLASSIFY) && w_dec.valid;
      r_reject      <= (r_state == CLASSIFY) && !w_dec.valid;
      r_cycle_done  <= (r_state == MOVE_BACK) && (w_state_next == DONE);
    end
  end

  assign w_dir   = (r_state == MOVE_BACK) ? ~r_dir_out : r_dir_out;
  assign w_clear = (w_state_next != MOVE_OUT) && (w_state_next != MOVE_BACK);

  stepper_phase_gen u_phase_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_tick      (w_tick),
    .i_dir       (w_dir),
    .i_half_step (HALF_STEP),
    .i_clear_out (w_clear),
    .o_coil      (motor_pregrada)
  );

  assign busy        = (r_state != IDLE);
  assign class_valid = r_class_valid;
  assign class_id    = r_class_id;
  assign reject      = r_reject;
  assign cycle_done  = r_cycle_done;

endmodule

// File: tb/tb_sorter_stepper_ctrl.sv
// Scoreboard bench: a full-step and a half-step controller share the same
// sensor stimulus; expected events are queued per instance and compared as
// each DUT produces them.
module tb_sorter_stepper_ctrl;

  localparam logic [2:0] K_CLASS  = 3'd1;
  localparam logic [2:0] K_REJECT = 3'd2;
  localparam logic [2:0] K_COIL   = 3'd3;
  localparam logic [2:0] K_DONE   = 3'd4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic enable = 1'b1;
  logic capacitive = 1'b1;
  logic inductive = 1'b0;
  logic photo = 1'b0;

  logic [3:0] motor       [2];
  logic       busy        [2];
  logic       class_valid [2];
  logic [1:0] class_id    [2];
  logic       reject      [2];
  logic       cycle_done  [2];
  logic [3:0] prev_motor  [2];

  logic [6:0] q_full[$];
  logic [6:0] q_half[$];

  logic [3:0] full_tab [4] = '{4'b1100, 4'b0110, 4'b0011, 4'b1001};
  logic [3:0] half_tab [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                               4'b0010, 4'b0011, 4'b0001, 4'b1001};
  logic [2:0] tb_dir_mask = 3'b101;
  int         m_idx [2] = '{0, 0};

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    sorter_stepper_ctrl #(
      .STEP_DELAY    (4),
      .DWELL_CYCLES  (10),
      .SETTLE_CYCLES (3),
      .STEPS_METAL   (16'd3),
      .STEPS_PLASTIC (16'd3),
      .STEPS_GLASS   (16'd5),
      .DIR_MASK      (3'b101),
      .HALF_STEP     (g == 1)
    ) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .enable         (enable),
      .capacitive     (capacitive),
      .inductive      (inductive),
      .photo          (photo),
      .motor_pregrada (motor[g]),
      .busy           (busy[g]),
      .class_valid    (class_valid[g]),
      .class_id       (class_id[g]),
      .reject         (reject[g]),
      .cycle_done     (cycle_done[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input int g, input logic [6:0] code);
    if (g == 0) q_full.push_back(code);
    else        q_half.push_back(code);
  endtask

  function automatic int steps_of(input int cls);
    return (cls == 2) ? 5 : 3;
  endfunction

  // Reference stepping model: coil = table[idx] on each tick, then idx moves.
  task automatic push_moves(input int g, input int steps, input bit fwd);
    int n;
    logic [3:0] coil;
    n = (g == 1) ? 8 : 4;
    for (int i = 0; i < steps; i++) begin
      coil = (g == 1) ? half_tab[m_idx[g]] : full_tab[m_idx[g]];
      push(g, {K_COIL, coil});
      m_idx[g] = fwd ? (m_idx[g] + 1) % n : (m_idx[g] + n - 1) % n;
    end
    if (steps > 0) push(g, {K_COIL, 4'b0000});
  endtask

  task automatic expect_cycle(input int cls, input bit full_cycle);
    bit fwd;
    fwd = tb_dir_mask[cls];
    for (int g = 0; g < 2; g++) begin
      push(g, {K_CLASS, 4'(cls)});
      push_moves(g, steps_of(cls), fwd);
      if (full_cycle) begin
        push_moves(g, steps_of(cls), !fwd);
        push(g, {K_DONE, 4'b0000});
      end
    end
  endtask

  task automatic observe(input int g, input logic [6:0] code);
    if (g == 0) begin
      if (q_full.size() == 0) check("unexpected_ev_full", 32'(code), 32'd0);
      else                    check("ev_full", 32'(code), 32'(q_full.pop_front()));
    end else begin
      if (q_half.size() == 0) check("unexpected_ev_half", 32'(code), 32'd0);
      else                    check("ev_half", 32'(code), 32'(q_half.pop_front()));
    end
  endtask

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (!rst_n) begin
        prev_motor[g] <= 4'b0000;
      end else begin
        if (class_valid[g]) observe(g, {K_CLASS, 2'b00, class_id[g]});
        if (reject[g])      observe(g, {K_REJECT, 4'b0000});
        if (motor[g] != prev_motor[g]) observe(g, {K_COIL, motor[g]});
        if (cycle_done[g])  observe(g, {K_DONE, 4'b0000});
        prev_motor[g] <= motor[g];
      end
    end
  end

  task automatic drive(input logic cap, input logic ind, input logic pho);
    capacitive = cap;
    inductive  = ind;
    photo      = pho;
  endtask

  task automatic wait_drain(input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      if (q_full.size() == 0 && q_half.size() == 0) break;
      @(negedge clk);
    end
    check({tag, "_left_full"}, 32'(q_full.size()), 32'd0);
    check({tag, "_left_half"}, 32'(q_half.size()), 32'd0);
    q_full.delete();
    q_half.delete();
  endtask

  task automatic wait_busy(input logic want, input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      if (busy[0] == want && busy[1] == want) break;
      @(negedge clk);
    end
    check(tag, 32'({busy[1], busy[0]}), want ? 32'd3 : 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int g = 0; g < 2; g++) begin
      check(tag, 32'({motor[g], busy[g], class_valid[g], class_id[g],
                      reject[g], cycle_done[g]}), 32'd0);
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("reset_outputs");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("idle_after_reset");

    // Metal: out forward three steps, dwell, back three steps.
    expect_cycle(0, 1'b1);
    drive(1'b0, 1'b1, 1'b1);
    wait_drain(400, "metal");
    wait_busy(1'b1, 2, "metal_wait_clear");
    drive(1'b1, 1'b0, 1'b0);
    wait_busy(1'b0, 10, "metal_idle");

    // Plastic: photo pulses for a single cycle inside the settle window.
    expect_cycle(1, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    wait_busy(1'b1, 10, "plastic_arm");
    photo = 1'b1;
    @(negedge clk);
    photo = 1'b0;
    wait_drain(400, "plastic");
    drive(1'b1, 1'b0, 1'b0);
    wait_busy(1'b0, 10, "plastic_idle");

    // Glass, then the same object held: no re-arm until it leaves.
    expect_cycle(2, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    wait_drain(400, "glass");
    repeat (8) @(negedge clk);
    check("hold_no_rearm", 32'({busy[1], busy[0]}), 32'd3);
    drive(1'b1, 1'b0, 1'b0);
    wait_busy(1'b0, 10, "glass_idle");

    // New object with an unknown pattern: reject, motor never moves.
    for (int g = 0; g < 2; g++) push(g, {K_REJECT, 4'b0000});
    drive(1'b0, 1'b1, 1'b0);
    wait_busy(1'b1, 10, "rearm");
    wait_drain(40, "reject");
    repeat (4) @(negedge clk);
    check("reject_wait_clear", 32'({busy[1], busy[0]}), 32'd3);
    drive(1'b1, 1'b0, 1'b0);
    wait_busy(1'b0, 10, "reject_idle");

    // Enable dropped mid-move: the cycle still completes, then no arming.
    expect_cycle(0, 1'b1);
    drive(1'b0, 1'b1, 1'b1);
    repeat (12) @(negedge clk);
    enable = 1'b0;
    wait_drain(400, "enable_drop");
    drive(1'b1, 1'b0, 1'b0);
    wait_busy(1'b0, 10, "enable_drop_idle");
    drive(1'b0, 1'b0, 1'b0);
    repeat (8) @(negedge clk);
    check("enable_low_no_arm", 32'({busy[1], busy[0]}), 32'd0);
    drive(1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    enable = 1'b1;

    // Glass outbound, then asynchronous reset in the dwell.
    expect_cycle(2, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    wait_drain(400, "glass_out");
    repeat (2) @(negedge clk);
    check("dwell_busy", 32'({busy[1], busy[0]}), 32'd3);
    check("dwell_class_id", 32'({class_id[1], class_id[0]}), 32'hA);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset_outputs");
    m_idx[0] = 0;
    m_idx[1] = 0;
    drive(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_idle", 32'({busy[1], busy[0]}), 32'd0);

    // Phase index restarted from zero after reset.
    expect_cycle(0, 1'b1);
    drive(1'b0, 1'b1, 1'b1);
    wait_drain(400, "metal_after_reset");
    drive(1'b1, 1'b0, 1'b0);
    wait_busy(1'b0, 10, "final_idle");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
